pixel_collector: RTL

Receive side of the flatten pixel stream. Captures one frame of `NUM_PIXELS` signed pixels from `flatten` into an internal buffer. Raises `frame_ready` once the frame is complete and exposes it through a registered random-access read port for the dense-layer engine. Also accumulates a signed frame sum, and flags short frames and overruns.

---
 rtl/pixel_collector.sv | 112 +++++++++++
 1 files changed

// File: rtl/pixel_collector.sv
// Frame capture buffer for the flatten pixel stream: collects NUM_PIXELS signed pixels,
// holds the frame for the dense-layer engine behind a registered read port.
module pixel_collector #(
   parameter int NUM_PIXELS = 784,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        pixel_in,
   input  logic                     pixel_valid,
   input  logic                     src_done,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic                     frame_release,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     frame_ready,
   output logic [CNT_W-1:0]         pixel_count,
   output logic [DATA_W+ADDR_W-1:0] frame_sum,
   output logic                     short_err,
   output logic                     overrun
);

   localparam int                MEM_AW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam logic [ADDR_W:0]   NUM_PIX_A = (ADDR_W+1)'(NUM_PIXELS);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_PIXELS - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      READY   = 1'b1
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] mem [NUM_PIXELS];
   logic              accept;
   logic              last_accept;
   logic              short_det;
   logic              drop;
   logic              release_ok;
   logic [MEM_AW-1:0] wr_idx;
   logic [MEM_AW-1:0] rd_idx;

   assign wr_idx = pixel_count[MEM_AW-1:0];
   assign rd_idx = rd_addr[MEM_AW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= COLLECT;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      last_accept = 1'b0;
      short_det   = 1'b0;
      drop        = 1'b0;
      release_ok  = 1'b0;
      case (state)
         COLLECT: begin
            accept      = pixel_valid;
            last_accept = pixel_valid && (pixel_count == LAST_IDX);
            // src_done together with the final pixel is a normal end of frame
            short_det   = src_done && !last_accept;
            if (last_accept) state_next = READY;
         end
         READY: begin
            drop       = pixel_valid;
            release_ok = frame_release;
            if (frame_release) state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   // frame_ready is the visible copy of the state register
   always_comb begin
      frame_ready = (state == READY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_count <= '0;
         frame_sum   <= '0;
         short_err   <= 1'b0;
         overrun     <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
      end else begin
         short_err <= short_det;
         if (release_ok || short_det) begin
            pixel_count <= '0;
            frame_sum   <= '0;
         end else if (accept) begin
            pixel_count <= pixel_count + 1'b1;
            frame_sum   <= frame_sum + {{ADDR_W{pixel_in[DATA_W-1]}}, pixel_in};
         end
         // a pixel dropped on the release cycle keeps the flag set
         if (drop)            overrun <= 1'b1;
         else if (release_ok) overrun <= 1'b0;
         rd_valid <= rd_en;
         if (rd_en) rd_data <= ({1'b0, rd_addr} < NUM_PIX_A) ? mem[rd_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_idx] <= pixel_in;
   end

endmodule
